// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: mask/value or external trigger, pre-trigger window,
// run-length-encoded ring buffer, and oldest-first valid/ready readout.
module la_capture_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int RLE_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    cqual,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [DATA_W-1:0]       trig_mask,
  input  logic [DATA_W-1:0]       trig_value,
  input  logic                    exttrig,
  input  logic [ADDR_W-1:0]       pretrig,
  output logic                    armed,
  output logic                    triggered,
  output logic                    busy,
  output logic                    rd_valid,
  output logic [RLE_W+DATA_W-1:0] rd_data,
  output logic                    rd_last,
  input  logic                    rd_ready
);
  localparam logic [ADDR_W:0]  DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [RLE_W-1:0] CNT_MAX = {RLE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DATA_W-1:0]         r_mask;
  logic [DATA_W-1:0]         r_value;
  logic [ADDR_W-1:0]         r_pretrig;
  logic [ADDR_W-1:0]         r_wptr;
  logic [ADDR_W:0]           r_wcnt;
  logic                      r_pend_vld;
  logic [RLE_W-1:0]          r_cur_cnt;
  logic [DATA_W-1:0]         r_cur_data;
  logic [ADDR_W-1:0]         r_trig_addr;
  logic [ADDR_W-1:0]         r_raddr;
  logic [ADDR_W:0]           r_rcnt;
  logic                      r_armed;
  logic                      r_triggered;
  logic                      r_busy;
  logic                      r_rd_valid;
  logic                      r_rd_last;
  logic [RLE_W+DATA_W-1:0]   r_rd_data;
  logic [RLE_W+DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic                      w_capt;
  logic                      w_match;
  logic                      w_trig;
  logic                      w_same;
  logic                      w_write;
  logic [ADDR_W:0]           w_wcnt_nxt;
  logic [ADDR_W:0]           w_post_tgt;
  logic                      w_hs;
  logic                      w_load;

  // Datapath decode: trigger match, RLE extend/flush and readout load enables
  always_comb begin
    w_capt     = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    w_match    = (r_mask != {DATA_W{1'b0}}) &&
                 (((data_in ^ r_value) & r_mask) == {DATA_W{1'b0}});
    w_trig     = (r_state == S_ARMED) && cqual && (exttrig || w_match);
    w_same     = r_pend_vld && (data_in == r_cur_data) && (r_cur_cnt != CNT_MAX);
    // a trigger always closes the pending word so the trigger sample owns its own entry
    w_write    = w_capt && cqual && r_pend_vld && (w_trig || !w_same);
    w_wcnt_nxt = r_wcnt + {{ADDR_W{1'b0}}, w_write};
    w_post_tgt = DEPTH_C - {1'b0, r_pretrig};
    w_hs       = r_rd_valid && rd_ready;
    w_load     = (r_state == S_READ) && (r_rcnt != DEPTH_C) && (!r_rd_valid || rd_ready);
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = arm ? S_PRE : S_IDLE;
        S_PRE:   w_state_nxt = (w_wcnt_nxt >= {1'b0, r_pretrig}) ? S_ARMED : S_PRE;
        S_ARMED: w_state_nxt = w_trig ? S_POST : S_ARMED;
        S_POST:  w_state_nxt = (w_write && (w_wcnt_nxt == w_post_tgt)) ? S_READ : S_POST;
        S_READ:  w_state_nxt = (w_hs && r_rd_last) ? S_IDLE : S_READ;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture buffer write port
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= {r_cur_cnt, r_cur_data};
    end
  end

  // Trigger config, RLE pending word, pointers and registered outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_mask      <= {DATA_W{1'b0}};
      r_value     <= {DATA_W{1'b0}};
      r_pretrig   <= {ADDR_W{1'b0}};
      r_wptr      <= {ADDR_W{1'b0}};
      r_wcnt      <= {(ADDR_W+1){1'b0}};
      r_pend_vld  <= 1'b0;
      r_cur_cnt   <= {RLE_W{1'b0}};
      r_cur_data  <= {DATA_W{1'b0}};
      r_trig_addr <= {ADDR_W{1'b0}};
      r_raddr     <= {ADDR_W{1'b0}};
      r_rcnt      <= {(ADDR_W+1){1'b0}};
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_rd_data   <= {(RLE_W+DATA_W){1'b0}};
    end else begin
      // pretrig can never exceed DEPTH-1 at this width, so no clamp is needed
      if ((r_state == S_IDLE) && arm) begin
        r_mask    <= trig_mask;
        r_value   <= trig_value;
        r_pretrig <= pretrig;
      end
      if (w_write) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_state_nxt != r_state) begin
        r_wcnt <= {(ADDR_W+1){1'b0}};
      end else if (w_capt) begin
        r_wcnt <= w_wcnt_nxt;
      end
      if ((w_state_nxt == S_IDLE) || (w_state_nxt == S_READ)) begin
        r_pend_vld <= 1'b0;
      end else if (w_capt && cqual) begin
        r_pend_vld <= 1'b1;
        if (w_same && !w_trig) begin
          r_cur_cnt <= r_cur_cnt + RLE_W'(1);
        end else begin
          r_cur_cnt  <= RLE_W'(1);
          r_cur_data <= data_in;
        end
      end
      if (w_trig) begin
        r_trig_addr <= r_pend_vld ? (r_wptr + ADDR_W'(1)) : r_wptr;
      end
      // readout starts pretrig words before the trigger entry, wrapping in the ring
      if (r_state != S_READ) begin
        r_raddr <= r_trig_addr - r_pretrig;
        r_rcnt  <= {(ADDR_W+1){1'b0}};
      end else if (w_load) begin
        r_raddr <= r_raddr + ADDR_W'(1);
        r_rcnt  <= r_rcnt + (ADDR_W+1)'(1);
      end
      r_armed     <= (w_state_nxt == S_ARMED);
      r_triggered <= (w_state_nxt == S_POST) || (w_state_nxt == S_READ);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_state_nxt != S_READ) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
        r_rd_data  <= {(RLE_W+DATA_W){1'b0}};
      end else if (w_load) begin
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_rcnt == (DEPTH_C - (ADDR_W+1)'(1)));
        r_rd_data  <= r_mem[r_raddr];
      end else if (w_hs) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign armed     = r_armed;
  assign triggered = r_triggered;
  assign busy      = r_busy;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core (DATA_W=8, ADDR_W=4, RLE_W=4) with hand-computed readouts.
module tb_la_capture_core;
  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        cqual;
  logic [7:0]  data_in;
  logic        arm;
  logic        abort;
  logic [7:0]  trig_mask;
  logic [7:0]  trig_value;
  logic        exttrig;
  logic [3:0]  pretrig;
  logic        rd_ready;
  logic        armed;
  logic        triggered;
  logic        busy;
  logic        rd_valid;
  logic [11:0] rd_data;
  logic        rd_last;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  cnt;
  logic [11:0] rbuf [NW];
  logic        lbuf [NW];
  int          nread;
  int          rcycles;
  int          qpost;

  la_capture_core #(.DATA_W(8), .ADDR_W(4), .RLE_W(4)) dut (
    .clk(clk), .rst_l(rst_l), .cqual(cqual), .data_in(data_in), .arm(arm),
    .abort(abort), .trig_mask(trig_mask), .trig_value(trig_value), .exttrig(exttrig),
    .pretrig(pretrig), .armed(armed), .triggered(triggered), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_armed"}, 32'(armed), 32'd0);
    chk({tag, "_triggered"}, 32'(triggered), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
  endtask

  task automatic start(input logic [7:0] mask, input logic [7:0] val, input logic [3:0] pt);
    trig_mask  = mask;
    trig_value = val;
    pretrig    = pt;
    cnt        = 8'd0;
    data_in    = 8'd0;
    cqual      = 1'b1;
    arm        = 1'b1;
    tick();
    arm = 1'b0;
    cnt = 8'd1;
    chk("arm_busy", 32'(busy), 32'd1);
  endtask

  // mode 0: counter, every cycle qualified; 1: counter, only even values qualified;
  // 2: constant AA with exttrig on the first ARMED cycle
  task automatic stream(input int mode);
    bit done;
    done  = 1'b0;
    qpost = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      data_in = (mode == 2) ? 8'hAA : cnt;
      cqual   = (mode == 1) ? ~cnt[0] : 1'b1;
      exttrig = (mode == 2) && armed;
      if (cqual && triggered) qpost++;
      tick();
      cnt = cnt + 8'd1;
      if (rd_valid) done = 1'b1;
    end
    exttrig = 1'b0;
    cqual   = 1'b0;
    chk("stream_reaches_read", 32'(done), 32'd1);
  endtask

  task automatic read_words(input bit stall);
    logic [12:0] hold;
    bit          hv;
    nread   = 0;
    rcycles = 0;
    for (int i = 0; i < NW; i++) begin
      rbuf[i] = 12'hFFF;
      lbuf[i] = 1'bx;
    end
    for (int n = 0; n < 400 && nread < NW; n++) begin
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        rbuf[nread] = rd_data;
        lbuf[nread] = rd_last;
        nread++;
      end
      hold = {rd_last, rd_data};
      hv   = rd_valid && !rd_ready;
      tick();
      rcycles++;
      if (hv) begin
        chk("stall_valid_held", 32'(rd_valid), 32'd1);
        chk("stall_word_held", 32'({rd_last, rd_data}), 32'(hold));
      end
    end
    rd_ready = 1'b1;
    chk("read_word_count", 32'(nread), 32'(NW));
    chk_idle("after_read");
  endtask

  task automatic check_words(input string tag, input logic [7:0] first,
                             input logic [7:0] stepv, input logic [3:0] cntv);
    logic [7:0] d;
    for (int i = 0; i < NW; i++) begin
      d = first + stepv * 8'(i);
      chk($sformatf("%s_w%0d", tag, i), 32'(rbuf[i]), 32'({cntv, d}));
      chk($sformatf("%s_last%0d", tag, i), 32'(lbuf[i]), 32'(i == NW - 1));
    end
  endtask

  initial begin
    bit seen;
    rst_l = 1'b0; cqual = 1'b0; data_in = 8'd0; arm = 1'b0; abort = 1'b0;
    trig_mask = 8'd0; trig_value = 8'd0; exttrig = 1'b0; pretrig = 4'd0; rd_ready = 1'b1;
    cnt = 8'd0;

    // 1. reset with random inputs, then idle until armed
    for (int i = 0; i < 4; i++) begin
      data_in = 8'($urandom); cqual = 1'($urandom); arm = 1'($urandom);
      abort = 1'($urandom); exttrig = 1'($urandom); trig_mask = 8'($urandom);
      trig_value = 8'($urandom); pretrig = 4'($urandom); rd_ready = 1'($urandom);
      tick();
      chk_idle("reset");
      chk("reset_rd_last", 32'(rd_last), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);
    end
    arm = 1'b0; abort = 1'b0; exttrig = 1'b0; rd_ready = 1'b1;
    rst_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'($urandom); cqual = 1'($urandom);
      tick();
    end
    chk_idle("post_reset");

    // 2. basic capture
    start(8'hFF, 8'h55, 4'd4);
    stream(0);
    read_words(1'b0);
    check_words("basic", 8'h51, 8'h01, 4'h1);
    chk("basic_no_bubbles", 32'(rcycles), 32'(NW));

    // 3. RLE saturation on constant data
    start(8'h00, 8'h00, 4'd0);
    stream(2);
    chk("rle_post_samples", 32'((qpost >= 241) && (qpost <= 242)), 32'd1);
    read_words(1'b0);
    check_words("rle", 8'hAA, 8'h00, 4'hF);

    // 4. qualifier gating: only even counter values sampled
    start(8'hFF, 8'h0A, 4'd2);
    stream(1);
    read_words(1'b0);
    check_words("qual", 8'h06, 8'h02, 4'h1);

    // 5. ring wrap with maximum pre-trigger window and stalled consumer
    start(8'hFF, 8'h28, 4'd15);
    stream(0);
    read_words(1'b1);
    check_words("wrap", 8'h19, 8'h01, 4'h1);

    // 6. abort during POST, abort beats arm, then re-run the basic case
    start(8'hFF, 8'h55, 4'd4);
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      data_in = cnt; cqual = 1'b1;
      tick();
      cnt = cnt + 8'd1;
      if (triggered) seen = 1'b1;
    end
    chk("abort_saw_trigger", 32'(seen), 32'd1);
    for (int n = 0; n < 3; n++) begin
      data_in = cnt; tick(); cnt = cnt + 8'd1;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      data_in = cnt; cqual = 1'b1; tick(); cnt = cnt + 8'd1;
      if (rd_valid || busy) seen = 1'b1;
    end
    chk("abort_stays_idle", 32'(seen), 32'd0);
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk_idle("abort_beats_arm");
    start(8'hFF, 8'h55, 4'd4);
    stream(0);
    read_words(1'b0);
    check_words("rearm", 8'h51, 8'h01, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
